// File: rtl/bbox_pkg.sv
// Shared types and constants for the bounding-box resample stage.
//   state_e : resample FSM state encoding
//   coord_t : 11-bit pixel coordinate as delivered by the box finder
//   GW_*    : grayscale weights, gray = (GW_R*R + GW_G*G + GW_B*B) >> GW_SHIFT
//   BG      : background byte written for empty boxes
package bbox_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_COORD = 4'd1,
    S_RD_R  = 4'd2,
    S_RD_G  = 4'd3,
    S_RD_B  = 4'd4,
    S_WAIT  = 4'd5,
    S_WR    = 4'd6,
    S_FILL  = 4'd7,
    S_DONE  = 4'd8
  } state_e;

  typedef logic [10:0] coord_t;

  localparam int unsigned GW_R     = 5;
  localparam int unsigned GW_G     = 9;
  localparam int unsigned GW_B     = 2;
  localparam int unsigned GW_SHIFT = 4;

  localparam logic [7:0] BG = 8'hFF;

endpackage

// File: rtl/bbox_resample_rgb_to_gray.sv
// rgb_to_gray: combinational RGB -> 8-bit gray conversion.
//   r, g, b : input colour bytes
//   gray    : weighted luminance, or a binarized 00/FF value when the
//             BBOX_BINARIZE_EN macro is defined (threshold THRESH)
// The weights sum to 16, so the 12-bit sum shifted by 4 never exceeds 255.
module rgb_to_gray
  import bbox_pkg::*;
#(
  parameter logic [7:0] THRESH = 8'd250
) (
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] gray
);

`ifdef BBOX_BINARIZE_EN
  localparam bit BIN_EN = 1'b1;
`else
  localparam bit BIN_EN = 1'b0;
`endif

  logic [11:0] acc;
  logic [7:0]  lum;

  assign acc  = 12'(GW_R) * {4'h0, r} + 12'(GW_G) * {4'h0, g} + 12'(GW_B) * {4'h0, b};
  assign lum  = 8'(acc >> GW_SHIFT);
  assign gray = BIN_EN ? ((lum < THRESH) ? 8'h00 : BG) : lum;

endmodule

// File: rtl/bbox_resample.sv
// bbox_resample: reads the RGB pixels inside a bounding box from image
// memory, converts them to gray and nearest-neighbour resamples the box into
// an OUT_W x OUT_H tile written to the classifier's tile buffer.
//   clk, rst_n      : clock, synchronous active-low reset
//   start / done    : handshake; start sampled in IDLE and DONE only
//   xMin..yMax      : inclusive box corners, latched (and clamped) at start
//   rdaddr / rddata : byte-addressed image read, data one cycle after address
//   wraddr / wrdata / wren : tile write port, one strobe per tile pixel
// Optional build macro: BBOX_BINARIZE_EN (tile holds 00/FF instead of gray).
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start
// COORD  | register source coordinate (sx, sy) for tile pixel (ox, oy)
// RD_R   | present R address
// RD_G   | present G address, capture R
// RD_B   | present B address, capture G
// WAIT   | B arrives, gray computed and registered for the write
// WR     | tile write strobe, then advance (ox, oy)
// FILL   | empty box: write background, one pixel per cycle
// DONE   | tile complete, done held until next start
module bbox_resample
  import bbox_pkg::*;
#(
  parameter int         WIDTH      = 100,
  parameter int         HEIGHT     = 100,
  parameter int         LOG2_OUT_W = 4,
  parameter int         LOG2_OUT_H = 4,
  parameter logic [7:0] THRESH     = 8'd250
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  output logic                             done,
  input  logic [10:0]                      xMin,
  input  logic [10:0]                      xMax,
  input  logic [10:0]                      yMin,
  input  logic [10:0]                      yMax,
  output logic [31:0]                      rdaddr,
  input  logic [15:0]                      rddata,
  output logic [LOG2_OUT_W+LOG2_OUT_H-1:0] wraddr,
  output logic [7:0]                       wrdata,
  output logic                             wren
);

  localparam int          AW        = LOG2_OUT_W + LOG2_OUT_H;
  localparam int          PXW       = LOG2_OUT_W + 12;
  localparam int          PYW       = LOG2_OUT_H + 12;
  localparam coord_t      X_LAST    = coord_t'(WIDTH - 1);
  localparam coord_t      Y_LAST    = coord_t'(HEIGHT - 1);
  localparam logic [31:0] ROW_PITCH = 32'(3 * WIDTH);

  state_e                  state_q, state_d;
  coord_t                  xmin_q, xmin_d, xmax_q, xmax_d;
  coord_t                  ymin_q, ymin_d, ymax_q, ymax_d;
  coord_t                  sx_q, sx_d, sy_q, sy_d;
  logic [LOG2_OUT_W-1:0]   ox_q, ox_d;
  logic [LOG2_OUT_H-1:0]   oy_q, oy_d;
  logic [7:0]              r_q, r_d, g_q, g_d;
  logic [31:0]             rdaddr_q;
  logic [AW-1:0]           wraddr_q, wraddr_d;
  logic [7:0]              wrdata_q, wrdata_d;
  logic                    wren_q, wren_d;
  logic                    done_q, done_d;

  coord_t                  xmax_clamp, ymax_clamp;
  logic                    box_empty;
  logic [11:0]             bw, bh;
  logic [PXW-1:0]          x_prod, x_off;
  logic [PYW-1:0]          y_prod, y_off;
  coord_t                  sx_next, sy_next;
  logic [31:0]             pix_addr;
  logic [AW-1:0]           pix_idx, pix_next;
  logic                    last_px;
  logic [7:0]              gray;

  assign xmax_clamp = (xMax > X_LAST) ? X_LAST : xMax;
  assign ymax_clamp = (yMax > Y_LAST) ? Y_LAST : yMax;
  // Also catches the box finder's no-ink result (xMin = W-1, xMax = 0).
  assign box_empty  = (xMin > xmax_clamp) || (yMin > ymax_clamp);

  assign bw      = {1'b0, xmax_q} - {1'b0, xmin_q} + 12'd1;
  assign bh      = {1'b0, ymax_q} - {1'b0, ymin_q} + 12'd1;
  assign x_prod  = PXW'(ox_q) * PXW'(bw);
  assign y_prod  = PYW'(oy_q) * PYW'(bh);
  assign x_off   = x_prod >> LOG2_OUT_W;
  assign y_off   = y_prod >> LOG2_OUT_H;
  // Offsets are always < bw / bh, so the 11-bit sums stay inside the box.
  assign sx_next = xmin_q + x_off[10:0];
  assign sy_next = ymin_q + y_off[10:0];

  assign pix_addr = 32'(sy_q) * ROW_PITCH + 32'(sx_q) * 32'd3;

  // {oy, ox} as one raster index: incrementing it wraps ox and carries into oy.
  assign pix_idx  = {oy_q, ox_q};
  assign pix_next = pix_idx + AW'(1);
  assign last_px  = &pix_idx;

  // B is taken straight off the read bus in WAIT and folded into wrdata.
  rgb_to_gray #(.THRESH(THRESH)) u_gray (
    .r    (r_q),
    .g    (g_q),
    .b    (rddata[7:0]),
    .gray (gray)
  );

  always_comb begin
    rdaddr = rdaddr_q;
    case (state_q)
      S_RD_R:  rdaddr = pix_addr;
      S_RD_G:  rdaddr = pix_addr + 32'd1;
      S_RD_B:  rdaddr = pix_addr + 32'd2;
      default: rdaddr = rdaddr_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    xmin_d   = xmin_q;
    xmax_d   = xmax_q;
    ymin_d   = ymin_q;
    ymax_d   = ymax_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    r_d      = r_q;
    g_d      = g_q;
    wraddr_d = wraddr_q;
    wrdata_d = wrdata_q;
    wren_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          xmin_d = xMin;
          xmax_d = xmax_clamp;
          ymin_d = yMin;
          ymax_d = ymax_clamp;
          ox_d   = '0;
          oy_d   = '0;
          if (box_empty) begin
            state_d  = S_FILL;
            wren_d   = 1'b1;
            wraddr_d = '0;
            wrdata_d = BG;
          end else begin
            state_d = S_COORD;
          end
        end
      end
      S_COORD: begin
        sx_d    = sx_next;
        sy_d    = sy_next;
        state_d = S_RD_R;
      end
      S_RD_R: state_d = S_RD_G;
      S_RD_G: begin
        r_d     = rddata[7:0];
        state_d = S_RD_B;
      end
      S_RD_B: begin
        g_d     = rddata[7:0];
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wren_d   = 1'b1;
        wraddr_d = pix_idx;
        wrdata_d = gray;
        state_d  = S_WR;
      end
      S_WR: begin
        if (last_px) begin
          state_d = S_DONE;
        end else begin
          {oy_d, ox_d} = pix_next;
          state_d      = S_COORD;
        end
      end
      S_FILL: begin
        if (last_px) begin
          state_d = S_DONE;
        end else begin
          {oy_d, ox_d} = pix_next;
          wren_d       = 1'b1;
          wraddr_d     = pix_next;
          wrdata_d     = BG;
        end
      end
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      xmin_q   <= '0;
      xmax_q   <= '0;
      ymin_q   <= '0;
      ymax_q   <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      r_q      <= '0;
      g_q      <= '0;
      rdaddr_q <= '0;
      wraddr_q <= '0;
      wrdata_q <= '0;
      wren_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      xmin_q   <= xmin_d;
      xmax_q   <= xmax_d;
      ymin_q   <= ymin_d;
      ymax_q   <= ymax_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      r_q      <= r_d;
      g_q      <= g_d;
      rdaddr_q <= rdaddr;
      wraddr_q <= wraddr_d;
      wrdata_q <= wrdata_d;
      wren_q   <= wren_d;
      done_q   <= done_d;
    end
  end

  assign done   = done_q;
  assign wraddr = wraddr_q;
  assign wrdata = wrdata_q;
  assign wren   = wren_q;

endmodule

// File: tb/tb_bbox_resample.sv
// Testbench for bbox_resample: 100x100 image memory model, tile capture,
// and a behavioural resample reference computed from box/tile arithmetic.
module tb_bbox_resample;

  localparam int W = 100;
  localparam int H = 100;
  localparam int NPIX = 256;
  localparam int LAT_RUN = 1537;
  localparam int LAT_FILL = 257;
`ifdef BBOX_BINARIZE_EN
  localparam int PX_RED = 0;
`else
  localparam int PX_RED = 79;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic [10:0] xMin = '0, xMax = '0, yMin = '0, yMax = '0;
  logic [31:0] rdaddr;
  logic [15:0] rddata = '0;
  logic [7:0]  wraddr;
  logic [7:0]  wrdata;
  logic        wren;

  always #5 clk = ~clk;

  bbox_resample #(
    .WIDTH(W), .HEIGHT(H), .LOG2_OUT_W(4), .LOG2_OUT_H(4), .THRESH(8'd250)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done),
    .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax),
    .rdaddr(rdaddr), .rddata(rddata),
    .wraddr(wraddr), .wrdata(wrdata), .wren(wren)
  );

  logic [7:0] mem [0:3*W*H-1];
  logic [7:0] tile [0:NPIX-1];
  int exp_tile [0:NPIX-1];
  int wr_cnt = 0, wr_base = 0, order_err = 0;
  int checks = 0, errors = 0;
  logic [31:0] last_a0, last_a1, last_a2;

  // Memory: one-cycle read latency, junk in the unused upper byte.
  always @(posedge clk) begin
    if (rdaddr < 32'(3*W*H)) rddata <= {8'($urandom), mem[int'(rdaddr)]};
    else rddata <= {8'($urandom), 8'h00};
  end

  always @(posedge clk) begin
    if (wren) begin
      tile[wraddr] = wrdata;
      if (int'(wraddr) != ((wr_cnt - wr_base) % NPIX)) order_err++;
      wr_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int gray_of(input int r, input int g, input int b);
    int v;
    v = (5*r + 9*g + 2*b) / 16;
`ifdef BBOX_BINARIZE_EN
    v = (v < 250) ? 0 : 255;
`endif
    return v;
  endfunction

  function automatic int src_gray(input int x, input int y);
    int a;
    a = (y*W + x) * 3;
    return gray_of(int'(mem[a]), int'(mem[a+1]), int'(mem[a+2]));
  endfunction

  // Reference: clamp, emptiness, nearest-neighbour source pick per tile pixel.
  task automatic model(input int x0, input int x1, input int y0, input int y1, output bit empty);
    int bw, bh, sx, sy;
    if (x1 > W-1) x1 = W-1;
    if (y1 > H-1) y1 = H-1;
    empty = (x0 > x1) || (y0 > y1);
    bw = x1 - x0 + 1;
    bh = y1 - y0 + 1;
    for (int oy = 0; oy < 16; oy++)
      for (int ox = 0; ox < 16; ox++) begin
        if (empty) exp_tile[oy*16+ox] = 255;
        else begin
          sx = x0 + (ox*bw) / 16;
          sy = y0 + (oy*bh) / 16;
          exp_tile[oy*16+ox] = src_gray(sx, sy);
        end
      end
  endtask

  // mode 0 white, 1 random, 2 column ramp R=G=B=x, 3 solid rgb
  task automatic fill_image(input int mode, input logic [23:0] rgb);
    int a;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        a = (y*W + x) * 3;
        case (mode)
          0: begin mem[a] = 8'hFF; mem[a+1] = 8'hFF; mem[a+2] = 8'hFF; end
          1: begin mem[a] = 8'($urandom); mem[a+1] = 8'($urandom); mem[a+2] = 8'($urandom); end
          2: begin mem[a] = 8'(x); mem[a+1] = 8'(x); mem[a+2] = 8'(x); end
          default: begin mem[a] = rgb[23:16]; mem[a+1] = rgb[15:8]; mem[a+2] = rgb[7:0]; end
        endcase
      end
  endtask

  task automatic run_box(input int x0, input int x1, input int y0, input int y1, input int pulse_at,
                         output int lat, output int rd_changed);
    int n;
    logic [31:0] rd0;
    @(negedge clk);
    xMin = 11'(x0); xMax = 11'(x1); yMin = 11'(y0); yMax = 11'(y1);
    start = 1'b1;
    wr_base = wr_cnt;
    rd0 = rdaddr;
    rd_changed = 0;
    last_a0 = '0; last_a1 = '0; last_a2 = '0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    // Box inputs must have been latched at start.
    xMin = 11'($urandom); xMax = 11'($urandom); yMin = 11'($urandom); yMax = 11'($urandom);
    check("done_drop", {31'd0, done}, 32'd0);
    while (!done && n < 3000) begin
      if (n == 2) last_a0 = rdaddr;
      if (n == 3) last_a1 = rdaddr;
      if (n == 4) last_a2 = rdaddr;
      if (rdaddr !== rd0) rd_changed = 1;
      start = (n == pulse_at);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    lat = done ? n : -1;
  endtask

  task automatic do_run(input string tag, input int x0, input int x1, input int y0, input int y1,
                        input int pulse_at, input int exp_lat, input int exp_px);
    int lat, rdc, mism, cmism, oe0;
    bit empty;
    model(x0, x1, y0, y1, empty);
    oe0 = order_err;
    run_box(x0, x1, y0, y1, pulse_at, lat, rdc);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_writes"}, wr_cnt - wr_base, NPIX);
    check({tag, "_wr_order"}, order_err - oe0, 0);
    mism = 0;
    cmism = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (int'(tile[i]) != exp_tile[i]) mism++;
      if (exp_px >= 0 && int'(tile[i]) != exp_px) cmism++;
    end
    check({tag, "_tile_mismatches"}, mism, 0);
    if (exp_px >= 0) check({tag, "_const_mismatches"}, cmism, 0);
    if (exp_lat == LAT_FILL) check({tag, "_fill_rdaddr_moved"}, rdc, 0);
  endtask

  typedef struct {
    int          x0, x1, y0, y1;
    int          mode;
    logic [23:0] rgb;
    int          exp_lat;
    int          exp_px;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int mism, x0, x1, y0, y1, n, snap;
    bit empty;

    vecs.push_back('{0, 99, 0, 99, 0, 24'h0, LAT_RUN, 255});
    vecs.push_back('{10, 25, 20, 35, 1, 24'h0, LAT_RUN, -1});
    vecs.push_back('{0, 31, 0, 15, 2, 24'h0, LAT_RUN, -1});
    vecs.push_back('{99, 0, 0, 99, 0, 24'h0, LAT_FILL, 255});
    vecs.push_back('{50, 50, 50, 50, 3, 24'hFF0000, LAT_RUN, PX_RED});
    vecs.push_back('{5, 5, 5, 5, 3, 24'h000000, LAT_RUN, 0});
    vecs.push_back('{5, 5, 5, 5, 3, 24'hFFFFFF, LAT_RUN, 255});
    vecs.push_back('{40, 150, 90, 200, 1, 24'h0, LAT_RUN, -1});
    vecs.push_back('{120, 130, 0, 10, 1, 24'h0, LAT_FILL, 255});
    vecs.push_back('{0, 99, 50, 20, 1, 24'h0, LAT_FILL, 255});

    fill_image(0, 24'h0);
    repeat (3) @(negedge clk);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wren", {31'd0, wren}, 32'd0);
    check("rst_wraddr", {24'd0, wraddr}, 32'd0);
    check("rst_wrdata", {24'd0, wrdata}, 32'd0);
    check("rst_rdaddr", rdaddr, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      fill_image(vecs[i].mode, vecs[i].rgb);
      do_run($sformatf("vec%0d", i), vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1,
             -1, vecs[i].exp_lat, vecs[i].exp_px);
    end

    // 1:1 copy: first read addresses and direct source correspondence.
    fill_image(1, 24'h0);
    do_run("copy", 10, 25, 20, 35, -1, LAT_RUN, -1);
    check("copy_rd_r", last_a0, 32'd6030);
    check("copy_rd_g", last_a1, 32'd6031);
    check("copy_rd_b", last_a2, 32'd6032);
    mism = 0;
    for (int j = 0; j < 16; j++)
      for (int i = 0; i < 16; i++)
        if (int'(tile[j*16+i]) != src_gray(10+i, 20+j)) mism++;
    check("copy_direct_mismatches", mism, 0);

    // 2:1 horizontal downsample on a column ramp: tile column i = source column 2i.
    fill_image(2, 24'h0);
    do_run("ramp", 0, 31, 0, 15, -1, LAT_RUN, -1);
    mism = 0;
    for (int i = 0; i < 16; i++)
      if (int'(tile[i]) != gray_of(2*i, 2*i, 2*i)) mism++;
    check("ramp_row0_mismatches", mism, 0);

    // start pulsed mid-run is ignored.
    fill_image(1, 24'h0);
    do_run("midstart", 3, 70, 8, 44, 500, LAT_RUN, -1);

    // Reset during pixel 100, then a full clean run.
    @(negedge clk);
    xMin = 11'd5; xMax = 11'd60; yMin = 11'd10; yMax = 11'd90;
    start = 1'b1;
    wr_base = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while ((wr_cnt - wr_base) < 100 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_px100", wr_cnt - wr_base, 100);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    snap = wr_cnt;
    check("midrst_wren", {31'd0, wren}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_rdaddr", rdaddr, 32'd0);
    repeat (3) @(negedge clk);
    check("midrst_no_writes", wr_cnt - snap, 0);
    rst_n = 1'b1;
    @(negedge clk);
    do_run("after_rst", 5, 60, 10, 90, -1, LAT_RUN, -1);

    // Random boxes against the reference model.
    for (int k = 0; k < 4; k++) begin
      fill_image(1, 24'h0);
      x0 = $urandom_range(0, 110);
      x1 = $urandom_range(0, 130);
      y0 = $urandom_range(0, 110);
      y1 = $urandom_range(0, 130);
      if (k < 2 && x0 > x1) begin n = x0; x0 = x1; x1 = n; end
      if (k < 2 && y0 > y1) begin n = y0; y0 = y1; y1 = n; end
      model(x0, x1, y0, y1, empty);
      do_run($sformatf("rand%0d", k), x0, x1, y0, y1, -1, empty ? LAT_FILL : LAT_RUN, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
